// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the instruction/data memory arbiter.
// master: the arbiter itself. slave: the requesters plus the memory.
interface mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        err;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ready;
    logic [31:0] m_rdata;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ready, m_rdata,
        output i_ack, i_rdata, d_ack, d_rdata, err, m_req, m_we, m_addr, m_wdata
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ready, m_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata, err, m_req, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: data-first priority with an anti-starvation
// escape for instruction fetches, one outstanding transfer, busy timeout.
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input logic           clk,
    input logic           reset,
    mem_arbiter_if.master bus
);

    localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam int unsigned BW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] StarveMax = SW'(STARVE_MAX);
    localparam logic [BW-1:0] BusyLast  = BW'(TIMEOUT - 1);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e        state_q, state_d;
    logic          m_req_q, m_req_d;
    logic          m_we_q, m_we_d;
    logic [31:0]   m_addr_q, m_addr_d;
    logic [31:0]   m_wdata_q, m_wdata_d;
    logic          i_ack_q, i_ack_d;
    logic          d_ack_q, d_ack_d;
    logic          err_q, err_d;
    logic [31:0]   i_rdata_q, i_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [BW-1:0] busy_q, busy_d;
    logic          win_data_q, win_data_d;

    // State register; reset drops everything at once, abandoning any transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            i_ack_q    <= 1'b0;
            d_ack_q    <= 1'b0;
            err_q      <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            starve_q   <= '0;
            busy_q     <= '0;
            win_data_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            i_ack_q    <= i_ack_d;
            d_ack_q    <= d_ack_d;
            err_q      <= err_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
            starve_q   <= starve_d;
            busy_q     <= busy_d;
            win_data_q <= win_data_d;
        end
    end

    // Arbitration in IDLE, completion/timeout tracking in BUSY.
    always_comb begin
        state_d    = state_q;
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        i_ack_d    = 1'b0;
        d_ack_d    = 1'b0;
        err_d      = 1'b0;
        i_rdata_d  = '0;
        d_rdata_d  = '0;
        starve_d   = starve_q;
        busy_d     = busy_q;
        win_data_d = win_data_q;

        case (state_q)
            StIdle: begin
                // The ack cycle is a recovery gap: the acked requester's req is
                // stale, and holding off the other one keeps the data-first
                // rotation intact under continuous contention.
                if (!i_ack_q && !d_ack_q) begin
                    if (bus.d_req && !(bus.i_req && starve_q == StarveMax)) begin
                        state_d    = StBusy;
                        m_req_d    = 1'b1;
                        m_we_d     = bus.d_we;
                        m_addr_d   = bus.d_addr;
                        m_wdata_d  = bus.d_wdata;
                        busy_d     = '0;
                        win_data_d = 1'b1;
                        if (!bus.i_req) begin
                            starve_d = '0;
                        end else if (starve_q != StarveMax) begin
                            starve_d = starve_q + SW'(1);
                        end
                    end else if (bus.i_req) begin
                        state_d    = StBusy;
                        m_req_d    = 1'b1;
                        m_we_d     = 1'b0;
                        m_addr_d   = bus.i_addr;
                        m_wdata_d  = '0;
                        busy_d     = '0;
                        win_data_d = 1'b0;
                        starve_d   = '0;
                    end
                end
            end
            StBusy: begin
                if (bus.m_ready) begin
                    state_d = StIdle;
                    m_req_d = 1'b0;
                    if (win_data_q) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = m_we_q ? 32'd0 : bus.m_rdata;
                    end else begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = bus.m_rdata;
                    end
                end else if (busy_q == BusyLast) begin
                    // Abort: ack with err so the requester is not left hanging.
                    state_d = StIdle;
                    m_req_d = 1'b0;
                    err_d   = 1'b1;
                    if (win_data_q) begin
                        d_ack_d = 1'b1;
                    end else begin
                        i_ack_d = 1'b1;
                    end
                end else begin
                    busy_d = busy_q + BW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                m_req_d = 1'b0;
            end
        endcase
    end

    assign bus.m_req   = m_req_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.i_ack   = i_ack_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_ack   = d_ack_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.err     = err_q;

endmodule
